// File: rtl/xor5_parity_checker.sv
// Serial frame receiver: DATA_W data bits (LSB first) plus one parity bit, checked with a
// running XOR and presented through a one-entry valid/ready buffer with overrun/error stats.
module xor5_parity_checker #(
    parameter int unsigned DATA_W     = 5,
    parameter bit          ODD_PARITY = 1'b0,
    parameter int unsigned CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_valid,
    input  logic              bit_in,
    input  logic              sync_clr,
    output logic [DATA_W-1:0] word_out,
    output logic              par_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int unsigned IdxW = $clog2(DATA_W);

    typedef enum logic [0:0] {StData, StPar} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              acc_q, acc_d;

    logic [DATA_W-1:0] word_q, word_d;
    logic              err_q, err_d;
    logic              valid_q, valid_d;
    logic              ovr_q, ovr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic frame_done;
    logic frame_err;

    // Frame assembly
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        frame_done = 1'b0;
        frame_err  = acc_q ^ bit_in ^ ODD_PARITY;

        if (sync_clr) begin
            state_d = StData;
            idx_d   = '0;
            acc_d   = 1'b0;
        end else if (bit_valid) begin
            unique case (state_q)
                StData: begin
                    shift_d[idx_q] = bit_in;
                    acc_d          = acc_q ^ bit_in;
                    if (idx_q == IdxW'(DATA_W - 1)) begin
                        state_d = StPar;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
                StPar: begin
                    frame_done = 1'b1;
                    state_d    = StData;
                    idx_d      = '0;
                    acc_d      = 1'b0;
                end
                default: state_d = StData;
            endcase
        end
    end

    // Output buffer; a completing frame may load into a slot that drains this same cycle
    always_comb begin
        word_d  = word_q;
        err_d   = err_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        cnt_d   = cnt_q;

        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        if (frame_done) begin
            if (!valid_q || out_ready) begin
                word_d  = shift_q;
                err_d   = frame_err;
                valid_d = 1'b1;
                if (frame_err && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                ovr_d = 1'b1;
            end
        end

        if (sync_clr) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StData;
            shift_q <= '0;
            idx_q   <= '0;
            acc_q   <= 1'b0;
            word_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            word_q  <= word_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign word_out  = word_q;
    assign par_err   = err_q;
    assign out_valid = valid_q;
    assign overrun   = ovr_q;
    assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_xor5_parity_checker.sv
// Bench for xor5_parity_checker: even and odd parity instances share one stimulus stream and
// are checked every cycle against a frame-level model, plus directed literal checks.
module tb_xor5_parity_checker;

    localparam int DW = 5;

    logic clk;
    logic rst_n;
    logic bit_valid, bit_in, sync_clr, out_ready;

    logic [DW-1:0] word_e, word_o;
    logic          perr_e, perr_o, valid_e, valid_o, ovr_e, ovr_o;
    logic [7:0]    cnt_e, cnt_o;

    int total = 0;
    int bad   = 0;

    xor5_parity_checker #(.DATA_W(DW), .ODD_PARITY(1'b0), .CNT_W(8)) dut_even (
        .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in),
        .sync_clr(sync_clr), .word_out(word_e), .par_err(perr_e), .out_valid(valid_e),
        .out_ready(out_ready), .overrun(ovr_e), .err_cnt(cnt_e)
    );

    xor5_parity_checker #(.DATA_W(DW), .ODD_PARITY(1'b1), .CNT_W(8)) dut_odd (
        .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in),
        .sync_clr(sync_clr), .word_out(word_o), .par_err(perr_o), .out_valid(valid_o),
        .out_ready(out_ready), .overrun(ovr_o), .err_cnt(cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame-level model
    bit          mq[$];
    logic [DW-1:0] m_word;
    logic        m_err_e, m_err_o, m_valid, m_ovr;
    int          m_cnt_e, m_cnt_o;

    task automatic model_reset();
        mq.delete();
        m_word  = '0;
        m_err_e = 1'b0;
        m_err_o = 1'b0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_cnt_e = 0;
        m_cnt_o = 0;
    endtask

    task automatic model_step();
        int            ones;
        logic [DW-1:0] w;
        logic          old_valid;
        old_valid = m_valid;
        if (m_valid && out_ready) m_valid = 1'b0;
        if (sync_clr) begin
            mq.delete();
            m_ovr = 1'b0;
        end else if (bit_valid) begin
            if (mq.size() < DW) begin
                mq.push_back(bit_in);
            end else begin
                w    = '0;
                ones = int'(bit_in);
                foreach (mq[i]) begin
                    w    = w | (DW'(mq[i]) << i);
                    ones += int'(mq[i]);
                end
                mq.delete();
                if (!old_valid || out_ready) begin
                    m_valid = 1'b1;
                    m_word  = w;
                    m_err_e = (ones % 2) == 1;
                    m_err_o = (ones % 2) == 0;
                    if (m_err_e && m_cnt_e < 255) m_cnt_e++;
                    if (m_err_o && m_cnt_o < 255) m_cnt_o++;
                end else begin
                    m_ovr = 1'b1;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model
    initial begin
        forever begin
            @(negedge clk);
            chk("valid_e", 32'(valid_e), 32'(m_valid));
            chk("valid_o", 32'(valid_o), 32'(m_valid));
            chk("ovr_e", 32'(ovr_e), 32'(m_ovr));
            chk("ovr_o", 32'(ovr_o), 32'(m_ovr));
            chk("cnt_e", 32'(cnt_e), 32'(m_cnt_e));
            chk("cnt_o", 32'(cnt_o), 32'(m_cnt_o));
            if (m_valid) begin
                chk("word_e", 32'(word_e), 32'(m_word));
                chk("word_o", 32'(word_o), 32'(m_word));
                chk("perr_e", 32'(perr_e), 32'(m_err_e));
                chk("perr_o", 32'(perr_o), 32'(m_err_o));
            end
        end
    end

    task automatic send_bit(input bit b, input int gap);
        bit_valid = 1'b1;
        bit_in    = b;
        @(negedge clk);
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DW-1:0] w, input bit p, input int gap);
        for (int i = 0; i < DW; i++) send_bit(w[i], gap);
        send_bit(p, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        sync_clr  = 1'b0;
        out_ready = 1'b1;
        do_reset();
        chk("rst_valid", 32'(valid_e), 32'd0);
        chk("rst_word", 32'(word_e), 32'd0);
        chk("rst_ovr", 32'(ovr_e), 32'd0);
        chk("rst_cnt", 32'(cnt_e), 32'd0);

        // Good even frame 1,0,1,1,0 + parity 1
        send_frame(5'h0D, 1'b1, 0);
        chk("f1_valid", 32'(valid_e), 32'd1);
        chk("f1_word", 32'(word_e), 32'h0D);
        chk("f1_perr_e", 32'(perr_e), 32'd0);
        chk("f1_cnt_e", 32'(cnt_e), 32'd0);
        chk("f1_perr_o", 32'(perr_o), 32'd1);
        chk("f1_model_word", 32'(m_word), 32'h0D);
        chk("f1_model_err", 32'(m_err_e), 32'd0);

        // Same data, wrong parity
        send_frame(5'h0D, 1'b0, 0);
        chk("f2_word", 32'(word_e), 32'h0D);
        chk("f2_perr_e", 32'(perr_e), 32'd1);
        chk("f2_cnt_e", 32'(cnt_e), 32'd1);
        chk("f2_model_cnt", 32'(m_cnt_e), 32'd1);

        // Counter saturation after 300 error frames
        for (int i = 0; i < 299; i++) send_frame(5'h0D, 1'b0, 0);
        chk("sat_cnt_e", 32'(cnt_e), 32'd255);
        chk("sat_cnt_o", 32'(cnt_o), 32'd1);
        send_frame(5'h0D, 1'b0, 0);
        chk("sat_hold", 32'(cnt_e), 32'd255);

        // Overrun with consumer stalled
        do_reset();
        out_ready = 1'b0;
        send_frame(5'h0D, 1'b1, 0);
        send_frame(5'h12, 1'b0, 0);
        chk("ovr_valid", 32'(valid_e), 32'd1);
        chk("ovr_word", 32'(word_e), 32'h0D);
        chk("ovr_flag", 32'(ovr_e), 32'd1);
        chk("ovr_cnt_e", 32'(cnt_e), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("ovr_drain", 32'(valid_e), 32'd0);
        chk("ovr_sticky", 32'(ovr_e), 32'd1);

        // sync_clr clears overrun; then load in the same cycle as drain
        sync_clr = 1'b1;
        @(negedge clk);
        sync_clr = 1'b0;
        chk("clr_ovr", 32'(ovr_e), 32'd0);
        send_frame(5'h0D, 1'b1, 0);
        for (int i = 0; i < DW; i++) send_bit(i == 1 || i == 4, 0);
        out_ready = 1'b1;
        send_bit(1'b0, 0);
        chk("b2b_word", 32'(word_e), 32'h12);
        chk("b2b_perr", 32'(perr_e), 32'd0);
        chk("b2b_valid", 32'(valid_e), 32'd1);
        chk("b2b_ovr", 32'(ovr_e), 32'd0);

        // Partial frame aborted by sync_clr, with a bit presented in the same cycle
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b0, 0);
        sync_clr  = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        @(negedge clk);
        sync_clr  = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        out_ready = 1'b0;
        send_frame(5'h1F, 1'b1, 0);
        chk("sc_word", 32'(word_e), 32'h1F);
        chk("sc_perr", 32'(perr_e), 32'd0);
        chk("sc_valid", 32'(valid_e), 32'd1);

        // Asynchronous reset mid-frame
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(valid_e), 32'd0);
        chk("ar_word", 32'(word_e), 32'd0);
        chk("ar_cnt_o", 32'(cnt_o), 32'd0);
        chk("ar_ovr", 32'(ovr_e), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send_frame(5'h1F, 1'b1, 0);
        chk("ar_next_word", 32'(word_e), 32'h1F);
        chk("ar_next_perr", 32'(perr_e), 32'd0);

        // Odd parity with gapped bits
        send_frame(5'h00, 1'b1, 2);
        chk("odd_ok", 32'(perr_o), 32'd0);
        chk("odd_ok_even", 32'(perr_e), 32'd1);
        send_frame(5'h00, 1'b0, 0);
        chk("odd_bad", 32'(perr_o), 32'd1);
        send_frame(5'h00, 1'b0, 3);
        chk("odd_bad_gap", 32'(perr_o), 32'd1);
        chk("odd_word", 32'(word_o), 32'h00);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
